sha1_multiblock_ctrl: RTL and testbench

- Parametrised next-generation SHA-1 sequencer. Drives the message-word memory, the schedule/working-register datapath and the hash registers.
- Hashes 1..N 512-bit blocks back-to-back, with configurable memory read latency and round structure.
- Holds its own word, round and block counters internally, so no external comparator inputs are needed.
- Uses a start / busy / done / done_ack handshake.
- Issues one round strobe per cycle, instead of a multi-state loop per round.

---
 rtl/sha1_multiblock_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sha1_multiblock_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_multiblock_ctrl.sv
// SHA-1 multi-block sequencer: loads message words, runs the compression
// rounds and updates the hash registers for 1..N back-to-back blocks.
// All outputs are Moore-decoded from the state register and counters.
module sha1_multiblock_ctrl #(
  parameter int unsigned WORDS_PER_BLOCK = 16,
  parameter int unsigned ROUNDS          = 80,
  parameter int unsigned STAGE_ROUNDS    = 20,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned BLK_W           = 8,
  parameter int unsigned ADDR_W          = 12
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [BLK_W-1:0]                   num_blocks,
  input  logic                               done_ack,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic                               w_valid,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] w_idx,
  output logic                               round_en,
  output logic [$clog2(ROUNDS)-1:0]          round_idx,
  output logic [1:0]                         f_sel,
  output logic                               hash_init,
  output logic                               hash_update,
  output logic [BLK_W-1:0]                   blk_idx,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned WIDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned RIDX_W = $clog2(ROUNDS);
  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [WIDX_W-1:0] W_LAST    = WIDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [RIDX_W-1:0] R_LAST    = RIDX_W'(ROUNDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD_REQ,
    LOAD_WAIT,
    LOAD_CAPT,
    ROUND,
    UPDATE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BLK_W-1:0]  blk_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BLK_W-1:0]  nb_eff;
  logic              w_last;
  logic              r_last;
  logic              wait_last;
  logic              more_blocks;
  int unsigned       stage;

  // Derived flags shared by the counter and next-state logic.
  always_comb begin
    nb_eff      = (num_blocks == '0) ? BLK_W'(1) : num_blocks;
    w_last      = (w_idx == W_LAST);
    r_last      = (round_idx == R_LAST);
    wait_last   = (wait_cnt == WAIT_LAST);
    more_blocks = ({1'b0, blk_idx} + {{BLK_W{1'b0}}, 1'b1}) < {1'b0, blk_cnt};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Word, round, wait and block counters plus the latched block count.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt   <= '0;
      blk_idx   <= '0;
      w_idx     <= '0;
      round_idx <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE:      if (start) blk_cnt <= nb_eff;
        INIT: begin
          blk_idx   <= '0;
          w_idx     <= '0;
          round_idx <= '0;
          wait_cnt  <= '0;
        end
        LOAD_REQ:  wait_cnt <= '0;
        LOAD_WAIT: wait_cnt <= wait_cnt + 1'b1;
        LOAD_CAPT: w_idx <= w_last ? '0 : w_idx + 1'b1;
        ROUND:     round_idx <= r_last ? '0 : round_idx + 1'b1;
        UPDATE:    if (more_blocks) blk_idx <= blk_idx + 1'b1;
        DONE:      if (start) blk_cnt <= nb_eff;
        default:   ;
      endcase
    end
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_nxt   = state;
    mem_rd_en   = 1'b0;
    w_valid     = 1'b0;
    round_en    = 1'b0;
    hash_init   = 1'b0;
    hash_update = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = INIT;
      INIT: begin
        hash_init = 1'b1;
        busy      = 1'b1;
        state_nxt = LOAD_REQ;
      end
      LOAD_REQ: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        state_nxt = (MEM_LAT > 0) ? LOAD_WAIT : LOAD_CAPT;
      end
      LOAD_WAIT: begin
        busy = 1'b1;
        if (wait_last) state_nxt = LOAD_CAPT;
      end
      LOAD_CAPT: begin
        w_valid   = 1'b1;
        busy      = 1'b1;
        state_nxt = w_last ? ROUND : LOAD_REQ;
      end
      ROUND: begin
        round_en = 1'b1;
        busy     = 1'b1;
        if (r_last) state_nxt = UPDATE;
      end
      UPDATE: begin
        hash_update = 1'b1;
        busy        = 1'b1;
        state_nxt   = more_blocks ? LOAD_REQ : DONE;
      end
      DONE: begin
        done = 1'b1;
        // start wins over a simultaneous done_ack
        if (start)         state_nxt = INIT;
        else if (done_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round function select, saturating at the last stage.
  always_comb begin
    stage = 32'(round_idx) / STAGE_ROUNDS;
    f_sel = (stage >= 3) ? 2'd3 : 2'(stage);
  end

  assign mem_addr = ADDR_W'(blk_idx) * ADDR_W'(WORDS_PER_BLOCK) + ADDR_W'(w_idx);

endmodule

// File: tb/tb_sha1_multiblock_ctrl.sv
// Scoreboard bench for sha1_multiblock_ctrl: a default build plus
// MEM_LAT=0 and MEM_LAT=3 builds for read-to-capture latency.
module tb_sha1_multiblock_ctrl;

  localparam int unsigned WPB     = 16;
  localparam int unsigned ROUNDS  = 80;
  localparam int unsigned LAT     = 1;
  localparam int unsigned BLK_LAT = WPB * (LAT + 2) + ROUNDS + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic done_ack = 1'b0;
  logic [7:0] num_blocks = '0;

  logic        mem_rd_en, w_valid, round_en, hash_init, hash_update, busy, done;
  logic [11:0] mem_addr;
  logic [3:0]  w_idx;
  logic [6:0]  round_idx;
  logic [1:0]  f_sel;
  logic [7:0]  blk_idx;

  logic start_l = 1'b0;
  logic ack_l = 1'b0;
  logic [7:0] nb_l = 8'd1;

  logic        l0_rd, l0_wv, l0_ren, l0_init, l0_upd, l0_busy, l0_done;
  logic [11:0] l0_addr;
  logic [3:0]  l0_widx;
  logic [6:0]  l0_ridx;
  logic [1:0]  l0_fsel;
  logic [7:0]  l0_blk;

  logic        l3_rd, l3_wv, l3_ren, l3_init, l3_upd, l3_busy, l3_done;
  logic [11:0] l3_addr;
  logic [3:0]  l3_widx;
  logic [6:0]  l3_ridx;
  logic [1:0]  l3_fsel;
  logic [7:0]  l3_blk;

  sha1_multiblock_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks), .done_ack(done_ack),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .w_valid(w_valid), .w_idx(w_idx),
    .round_en(round_en), .round_idx(round_idx), .f_sel(f_sel), .hash_init(hash_init),
    .hash_update(hash_update), .blk_idx(blk_idx), .busy(busy), .done(done)
  );

  sha1_multiblock_ctrl #(.MEM_LAT(0)) dut_l0 (
    .clk(clk), .reset(reset), .start(start_l), .num_blocks(nb_l), .done_ack(ack_l),
    .mem_rd_en(l0_rd), .mem_addr(l0_addr), .w_valid(l0_wv), .w_idx(l0_widx),
    .round_en(l0_ren), .round_idx(l0_ridx), .f_sel(l0_fsel), .hash_init(l0_init),
    .hash_update(l0_upd), .blk_idx(l0_blk), .busy(l0_busy), .done(l0_done)
  );

  sha1_multiblock_ctrl #(.MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset), .start(start_l), .num_blocks(nb_l), .done_ack(ack_l),
    .mem_rd_en(l3_rd), .mem_addr(l3_addr), .w_valid(l3_wv), .w_idx(l3_widx),
    .round_en(l3_ren), .round_idx(l3_ridx), .f_sel(l3_fsel), .hash_init(l3_init),
    .hash_update(l3_upd), .blk_idx(l3_blk), .busy(l3_busy), .done(l3_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    int unsigned val;
  } ev_t;

  ev_t q_init[$];
  ev_t q_rd[$];
  ev_t q_wv[$];
  ev_t q_rnd[$];
  ev_t q_upd[$];
  ev_t q_done[$];

  function automatic int unsigned fsel_exp(input int unsigned r);
    return (r / 20 > 3) ? 3 : r / 20;
  endfunction

  function automatic logic [63:0] outs();
    return {24'b0, mem_rd_en, mem_addr, w_valid, w_idx, round_en, round_idx, f_sel,
            hash_init, hash_update, blk_idx, busy, done};
  endfunction

  // Expected event timeline for a start sampled at cycle t0.
  task automatic push_exp(input int unsigned t0, input int unsigned nb);
    int unsigned base;
    int unsigned load_end;
    q_init.push_back('{t0 + 1, 0});
    for (int unsigned b = 0; b < nb; b++) begin
      base = t0 + 2 + b * BLK_LAT;
      for (int unsigned w = 0; w < WPB; w++) begin
        q_rd.push_back('{base + w * (LAT + 2), b * WPB + w});
        q_wv.push_back('{base + w * (LAT + 2) + LAT + 1, w});
      end
      load_end = base + WPB * (LAT + 2);
      for (int unsigned r = 0; r < ROUNDS; r++)
        q_rnd.push_back('{load_end + r, r * 4 + fsel_exp(r)});
      q_upd.push_back('{load_end + ROUNDS, b});
    end
    q_done.push_back('{t0 + 2 + nb * BLK_LAT, 0});
  endtask

  task automatic flush();
    q_init.delete();
    q_rd.delete();
    q_wv.delete();
    q_rnd.delete();
    q_upd.delete();
    q_done.delete();
  endtask

  logic done_q = 1'b0;
  int unsigned t0l = 0;
  int unsigned l0_last_rd = 0, l3_last_rd = 0;
  int unsigned l0_wv_n = 0, l3_wv_n = 0;
  int unsigned l0_seen = 0, l3_seen = 0;
  logic l0_done_q = 1'b0, l3_done_q = 1'b0;

  // Scoreboard monitor: pop and compare on every observed event.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (hash_init) begin
        if (q_init.size() == 0) check("init_extra", 1, 0);
        else begin e = q_init.pop_front(); check("init_cyc", cyc, e.cyc); end
      end
      if (mem_rd_en) begin
        if (q_rd.size() == 0) check("rd_extra", 1, 0);
        else begin
          e = q_rd.pop_front();
          check("rd_cyc", cyc, e.cyc);
          check("rd_addr", mem_addr, e.val);
          check("rd_widx", w_idx, e.val % WPB);
        end
      end
      if (w_valid) begin
        if (q_wv.size() == 0) check("wv_extra", 1, 0);
        else begin
          e = q_wv.pop_front();
          check("wv_cyc", cyc, e.cyc);
          check("wv_idx", w_idx, e.val);
        end
      end
      if (round_en) begin
        if (q_rnd.size() == 0) check("rnd_extra", 1, 0);
        else begin
          e = q_rnd.pop_front();
          check("rnd_cyc", cyc, e.cyc);
          check("rnd_idx_fsel", {round_idx, f_sel}, e.val);
        end
      end
      if (hash_update) begin
        if (q_upd.size() == 0) check("upd_extra", 1, 0);
        else begin
          e = q_upd.pop_front();
          check("upd_cyc", cyc, e.cyc);
          check("upd_blk", blk_idx, e.val);
        end
      end
      if (done && !done_q) begin
        if (q_done.size() == 0) check("done_extra", 1, 0);
        else begin e = q_done.pop_front(); check("done_cyc", cyc, e.cyc); end
      end
      if (l0_rd) l0_last_rd = cyc;
      if (l3_rd) l3_last_rd = cyc;
      if (l0_wv) begin l0_wv_n++; check("l0_gap", cyc - l0_last_rd, 1); end
      if (l3_wv) begin l3_wv_n++; check("l3_gap", cyc - l3_last_rd, 4); end
      if (l0_done && !l0_done_q) begin l0_seen++; check("l0_done_cyc", cyc - t0l, 115); end
      if (l3_done && !l3_done_q) begin l3_seen++; check("l3_done_cyc", cyc - t0l, 163); end
    end
    done_q    <= done;
    l0_done_q <= l0_done;
    l3_done_q <= l3_done;
  end

  task automatic wait_done(input int unsigned limit);
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_round(input int unsigned r, input int unsigned limit);
    for (int unsigned i = 0; i < limit; i++) begin
      if (round_en && round_idx == 7'(r)) return;
      @(negedge clk);
    end
    check("round_timeout", 0, 1);
  endtask

  task automatic ack_done();
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    check("ack_done_low", done, 0);
    check("ack_busy_low", busy, 0);
  endtask

  task automatic kick(input logic [7:0] nb, input int unsigned nb_eff);
    @(negedge clk);
    start = 1'b1;
    num_blocks = nb;
    push_exp(cyc, nb_eff);
    @(negedge clk);
    start = 1'b0;
    num_blocks = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    reset = 1'b0;

    // single block, latency builds started alongside
    @(negedge clk);
    start = 1'b1; num_blocks = 8'd1; start_l = 1'b1; t0l = cyc;
    push_exp(cyc, 1);
    @(negedge clk);
    start = 1'b0; start_l = 1'b0;
    wait_done(400);
    ack_done();

    // three blocks, with an extra start during ROUND that must be ignored
    kick(8'd3, 3);
    wait_round(10, 2000);
    start = 1'b1; num_blocks = 8'd5;
    @(negedge clk);
    start = 1'b0; num_blocks = '0;
    check("ign_busy", busy, 1);
    check("ign_round_en", round_en, 1);
    wait_done(1000);

    // start and done_ack together in DONE, num_blocks=0 acts as 1
    start = 1'b1; done_ack = 1'b1; num_blocks = 8'd0;
    push_exp(cyc, 1);
    @(negedge clk);
    start = 1'b0; done_ack = 1'b0;
    check("restart_done_low", done, 0);
    check("restart_init", hash_init, 1);
    wait_done(400);
    ack_done();

    // reset in the middle of the rounds
    kick(8'd1, 1);
    wait_round(37, 400);
    reset = 1'b1;
    flush();
    @(negedge clk);
    check("abort_outs", outs(), 0);
    reset = 1'b0;
    kick(8'd1, 1);
    wait_done(400);
    ack_done();

    // maximum block count
    kick(8'd255, 255);
    wait_done(34000);
    ack_done();

    repeat (3) @(negedge clk);
    check("q_init_left", q_init.size(), 0);
    check("q_rd_left", q_rd.size(), 0);
    check("q_wv_left", q_wv.size(), 0);
    check("q_rnd_left", q_rnd.size(), 0);
    check("q_upd_left", q_upd.size(), 0);
    check("q_done_left", q_done.size(), 0);
    check("l0_wv_count", l0_wv_n, 16);
    check("l3_wv_count", l3_wv_n, 16);
    check("l0_done_seen", l0_seen, 1);
    check("l3_done_seen", l3_seen, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
